// File: rtl/floor_gen_if.sv
// Floor-platform bus: the slime mover supplies tick/slime_y; floor_gen
// returns the four floor slots, their enables, the score and game-over.
interface floor_gen_if;
  logic        tick;
  logic [9:0]  slime_y;
  logic [10:0] floor_pos_x0;
  logic [10:0] floor_pos_x1;
  logic [10:0] floor_pos_x2;
  logic [10:0] floor_pos_x3;
  logic [10:0] floor_pos_y0;
  logic [10:0] floor_pos_y1;
  logic [10:0] floor_pos_y2;
  logic [10:0] floor_pos_y3;
  logic [3:0]  enable;
  logic [15:0] score;
  logic        game_over;

  // floor_gen side
  modport master (
    input  tick, slime_y,
    output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    output floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    output enable, score, game_over
  );

  // consumer side (slime mover / renderer)
  modport slave (
    output tick, slime_y,
    input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    input  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    input  enable, score, game_over
  );
endinterface

// File: rtl/floor_gen.sv
// floor_gen: owns four floor slots. Scrolls them down while the slime is
// above the scroll line, retires floors falling off the bottom, respawns
// them at the top at an LFSR-chosen x, counts scroll steps as score and
// latches game-over when the slime reaches the bottom row.
// The *_INIT parameters hold the power-up layout; their defaults are the
// standard starting screen.
module floor_gen #(
  parameter logic [9:0]  SCROLL_LINE = 10'd240,
  parameter logic [10:0] MIN_GAP     = 11'd80,
  parameter logic [9:0]  X_MAX       = 10'd599,
  parameter logic [10:0] BOTTOM      = 11'd479,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [39:0] X_INIT      = {10'd80, 10'd420, 10'd160, 10'd300},
  parameter logic [39:0] Y_INIT      = {10'd99, 10'd199, 10'd299, 10'd399},
  parameter logic [3:0]  EN_INIT     = 4'b1111,
  parameter logic [15:0] SCORE_INIT  = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  floor_gen_if.master  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [9:0]  x_r [4];
  logic [9:0]  y_r [4];
  logic [9:0]  x_s [4];
  logic [9:0]  y_s [4];
  logic [3:0]  en_r, en_s;
  logic [15:0] score_r, score_s;
  logic [15:0] lfsr_r, lfsr_s;
  logic        scroll_s;
  logic        gap_ok_s;
  logic        spawn_s;
  logic [1:0]  slot_s;
  logic [9:0]  cand_x_s;

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Fold the 10-bit LFSR slice into the legal floor x range 0..X_MAX
  function automatic logic [9:0] fold_x(input logic [9:0] c);
    logic [9:0] r;
    if (c > X_MAX) begin
      r = c - 10'd424;
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Next-state logic: FSM, scroll/retire, respawn, score, LFSR
  always_comb begin
    state_s  = state_r;
    x_s      = x_r;
    y_s      = y_r;
    en_s     = en_r;
    score_s  = score_r;
    lfsr_s   = lfsr_next(lfsr_r);
    scroll_s = 1'b0;
    gap_ok_s = 1'b1;
    slot_s   = 2'd0;
    cand_x_s = fold_x(lfsr_r[9:0]);

    // Respawn is gated on the current registers only, so a slot retired
    // this cycle cannot come back until the next one.
    for (int n = 0; n < 4; n++) begin
      if (en_r[n] && ({1'b0, y_r[n]} < MIN_GAP)) begin
        gap_ok_s = 1'b0;
      end else begin
        gap_ok_s = gap_ok_s;
      end
    end
    for (int n = 3; n >= 0; n--) begin
      if (!en_r[n]) begin
        slot_s = 2'(n);
      end else begin
        slot_s = slot_s;
      end
    end
    spawn_s = gap_ok_s && (en_r != 4'b1111);

    case (state_r)
      ST_RUN: begin
        if (bus.slime_y == BOTTOM[9:0]) begin
          state_s = ST_OVER;
        end else begin
          state_s = ST_RUN;
        end
        scroll_s = bus.tick && (bus.slime_y < SCROLL_LINE);
        for (int n = 0; n < 4; n++) begin
          if (spawn_s && (slot_s == 2'(n))) begin
            // New floor lands at the top, unaffected by this cycle's scroll
            en_s[n] = 1'b1;
            y_s[n]  = 10'd0;
            x_s[n]  = cand_x_s;
          end else if (scroll_s && en_r[n]) begin
            if (({1'b0, y_r[n]} + 11'd1) > BOTTOM) begin
              en_s[n] = 1'b0;
              y_s[n]  = 10'd0;
            end else begin
              y_s[n]  = y_r[n] + 10'd1;
            end
          end else begin
            y_s[n] = y_r[n];
          end
        end
        if (scroll_s && (score_r != 16'hFFFF)) begin
          score_s = score_r + 16'd1;
        end else begin
          score_s = score_r;
        end
      end
      ST_OVER: begin
        state_s = ST_OVER;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State registers with synchronous reset to the starting screen
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      en_r    <= EN_INIT;
      score_r <= SCORE_INIT;
      lfsr_r  <= SEED;
      for (int n = 0; n < 4; n++) begin
        x_r[n] <= X_INIT[10*n +: 10];
        y_r[n] <= Y_INIT[10*n +: 10];
      end
    end else begin
      state_r <= state_s;
      en_r    <= en_s;
      score_r <= score_s;
      lfsr_r  <= lfsr_s;
      for (int n = 0; n < 4; n++) begin
        x_r[n] <= x_s[n];
        y_r[n] <= y_s[n];
      end
    end
  end

  assign bus.floor_pos_x0 = {1'b0, x_r[0]};
  assign bus.floor_pos_x1 = {1'b0, x_r[1]};
  assign bus.floor_pos_x2 = {1'b0, x_r[2]};
  assign bus.floor_pos_x3 = {1'b0, x_r[3]};
  assign bus.floor_pos_y0 = {1'b0, y_r[0]};
  assign bus.floor_pos_y1 = {1'b0, y_r[1]};
  assign bus.floor_pos_y2 = {1'b0, y_r[2]};
  assign bus.floor_pos_y3 = {1'b0, y_r[3]};
  assign bus.enable       = en_r;
  assign bus.score        = score_r;
  assign bus.game_over    = (state_r == ST_OVER);

endmodule

// File: tb/tb_floor_gen.sv
// Bench for floor_gen: three instances (standard layout, a layout with a
// retired slot plus a low floor and near-saturated score, and an all-empty
// layout) share one stimulus stream and are compared every cycle against
// a slot/queue-level reference model.
module tb_floor_gen;
  localparam logic [39:0] XI  = {10'd80, 10'd420, 10'd160, 10'd300};
  localparam logic [39:0] YA  = {10'd99, 10'd199, 10'd299, 10'd399};
  localparam logic [39:0] YB  = {10'd50, 10'd200, 10'd300, 10'd400};
  localparam logic [11:0] ENS = {4'b0000, 4'b1011, 4'b1111};
  localparam logic [47:0] SCS = {16'h0000, 16'hFFFE, 16'h0000};

  logic clk = 1'b0;
  logic rst_t = 1'b1;
  logic tick_t = 1'b0;
  logic [9:0] sy_t = 10'd300;
  int checks = 0;
  int errors = 0;

  logic [10:0] ox [3][4];
  logic [10:0] oy [3][4];
  logic [3:0]  oen [3];
  logic [15:0] osc [3];
  logic        ogo [3];

  floor_gen_if bus [3] ();

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    floor_gen #(
      .X_INIT(XI),
      .Y_INIT((gi == 1) ? YB : YA),
      .EN_INIT(ENS[4*gi +: 4]),
      .SCORE_INIT(SCS[16*gi +: 16])
    ) dut (
      .clk(clk),
      .rst(rst_t),
      .bus(bus[gi])
    );
    assign bus[gi].tick    = tick_t;
    assign bus[gi].slime_y = sy_t;
    assign ox[gi][0] = bus[gi].floor_pos_x0;
    assign ox[gi][1] = bus[gi].floor_pos_x1;
    assign ox[gi][2] = bus[gi].floor_pos_x2;
    assign ox[gi][3] = bus[gi].floor_pos_x3;
    assign oy[gi][0] = bus[gi].floor_pos_y0;
    assign oy[gi][1] = bus[gi].floor_pos_y1;
    assign oy[gi][2] = bus[gi].floor_pos_y2;
    assign oy[gi][3] = bus[gi].floor_pos_y3;
    assign oen[gi]   = bus[gi].enable;
    assign osc[gi]   = bus[gi].score;
    assign ogo[gi]   = bus[gi].game_over;
  end

  always #5 clk = ~clk;

  // Reference model: per-instance slots as plain integers
  int mx [3][4];
  int my [3][4];
  bit men [3][4];
  int mscore [3];
  bit mover [3];
  int mlfsr [3];

  task automatic model_step(input int i);
    int cand, spawn, fb;
    bit any_off, gap, scroll;
    logic [39:0] yi;
    logic [11:0] ens;
    logic [47:0] scs;
    if (rst_t) begin
      yi = (i == 1) ? YB : YA;
      ens = ENS;
      scs = SCS;
      for (int n = 0; n < 4; n++) begin
        mx[i][n]  = int'(XI[10*n +: 10]);
        my[i][n]  = int'(yi[10*n +: 10]);
        men[i][n] = ens[4*i + n];
      end
      mscore[i] = int'(scs[16*i +: 16]);
      mover[i]  = 1'b0;
      mlfsr[i]  = 'hACE1;
    end else begin
      cand = mlfsr[i] % 1024;
      if (cand > 599) cand = cand - 424;
      if (!mover[i]) begin
        scroll = tick_t && (int'(sy_t) < 240);
        any_off = 1'b0;
        gap = 1'b1;
        spawn = -1;
        for (int n = 0; n < 4; n++) begin
          if (!men[i][n]) any_off = 1'b1;
          else if (my[i][n] < 80) gap = 1'b0;
        end
        if (any_off && gap)
          for (int n = 3; n >= 0; n--) if (!men[i][n]) spawn = n;
        if (scroll)
          for (int n = 0; n < 4; n++)
            if (men[i][n]) begin
              if (my[i][n] + 1 > 479) begin
                men[i][n] = 1'b0;
                my[i][n]  = 0;
              end else my[i][n] = my[i][n] + 1;
            end
        if (spawn >= 0) begin
          men[i][spawn] = 1'b1;
          my[i][spawn]  = 0;
          mx[i][spawn]  = cand;
        end
        if (scroll && mscore[i] < 65535) mscore[i] = mscore[i] + 1;
        if (int'(sy_t) == 479) mover[i] = 1'b1;
      end
      fb = ((mlfsr[i] >> 15) ^ (mlfsr[i] >> 13) ^ (mlfsr[i] >> 12) ^ (mlfsr[i] >> 10)) & 1;
      mlfsr[i] = ((mlfsr[i] << 1) | fb) & 'hFFFF;
    end
  endtask

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic compare(input int i);
    logic [43:0] gx, ex, gy, ey;
    logic [3:0] een;
    for (int n = 0; n < 4; n++) begin
      gx[11*n +: 11] = ox[i][n];
      gy[11*n +: 11] = oy[i][n];
      ex[11*n +: 11] = 11'(mx[i][n]);
      ey[11*n +: 11] = 11'(my[i][n]);
      een[n] = men[i][n];
      checks++;
      if (ox[i][n] > 11'd599) begin
        errors++;
        $display("FAIL xrange inst%0d slot%0d got=%0d max=599", i, n, ox[i][n]);
      end
    end
    chk("floor_x", i, 64'(gx), 64'(ex));
    chk("floor_y", i, 64'(gy), 64'(ey));
    chk("enable", i, 64'(oen[i]), 64'(een));
    chk("score", i, 64'(osc[i]), 64'(mscore[i]));
    chk("game_over", i, 64'(ogo[i]), 64'(mover[i]));
  endtask

  task automatic run(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < 3; i++) compare(i);
    end
  endtask

  typedef struct {
    bit   rst;
    bit   tick;
    int   sy;
    int   n;
    int   ey0, ey1, ey2, ey3;
    int   ex0;
    logic [3:0] een;
    int   escore;
    bit   ego;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int snap_score;
    tbl[0] = '{1'b1, 1'b0, 300,  1, 399, 299, 199,  99, 300, 4'hF,  0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 200, 79, 478, 378, 278, 178, 300, 4'hF, 79, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 240,  3, 478, 378, 278, 178, 300, 4'hF, 79, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 239,  1, 479, 379, 279, 179, 300, 4'hF, 80, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 300,  2, 479, 379, 279, 179, 300, 4'hF, 80, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 100,  3, 479, 379, 279, 179, 300, 4'hF, 80, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 200,  1,   0, 380, 280, 180, 300, 4'hE, 81, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 200,  1,   0, 380, 280, 180,  -1, 4'hF, 81, 1'b0};

    // Alternate layouts: blocked respawn and all-empty start
    rst_t = 1'b1; tick_t = 1'b0; sy_t = 10'd300;
    run(1);
    rst_t = 1'b0;
    run(3);
    chk("b_blocked_en", 1, 64'(oen[1]), 64'(4'b1011));
    chk("b_score_init", 1, 64'(osc[1]), 64'(16'hFFFE));
    chk("c_slot0_first", 2, 64'(oen[2]), 64'(4'b0001));
    chk("c_y0_top", 2, 64'(oy[2][0]), 64'(11'd0));

    // Table-driven scroll / retire / respawn on the standard layout
    for (int v = 0; v < 8; v++) begin
      rst_t = tbl[v].rst; tick_t = tbl[v].tick; sy_t = 10'(tbl[v].sy);
      run(tbl[v].n);
      chk("tbl_y", v, {20'd0, oy[0][3], oy[0][2], oy[0][1], oy[0][0]},
          {20'd0, 11'(tbl[v].ey3), 11'(tbl[v].ey2), 11'(tbl[v].ey1), 11'(tbl[v].ey0)});
      chk("tbl_en", v, 64'(oen[0]), 64'(tbl[v].een));
      chk("tbl_score", v, 64'(osc[0]), 64'(tbl[v].escore));
      chk("tbl_go", v, 64'(ogo[0]), 64'(tbl[v].ego));
      if (tbl[v].ex0 >= 0) chk("tbl_x0", v, 64'(ox[0][0]), 64'(tbl[v].ex0));
    end
    chk("b_score_sat", 1, 64'(osc[1]), 64'(16'hFFFF));

    // Randomized play with occasional reset
    for (int k = 0; k < 4000; k++) begin
      rst_t  = ($urandom % 1000) == 0;
      tick_t = ($urandom % 4) != 0;
      if (($urandom % 5) != 0) sy_t = 10'($urandom_range(0, 239));
      else sy_t = 10'($urandom_range(240, 478));
      run(1);
    end

    // Game over: sticky, everything frozen, only reset exits
    rst_t = 1'b0; tick_t = 1'b1; sy_t = 10'd479;
    run(1);
    chk("go_set", 0, 64'(ogo[0]), 64'(1'b1));
    snap_score = mscore[0];
    sy_t = 10'd100;
    run(10);
    chk("go_sticky", 0, 64'(ogo[0]), 64'(1'b1));
    chk("go_score_frozen", 0, 64'(osc[0]), 64'(snap_score));
    rst_t = 1'b1;
    run(1);
    rst_t = 1'b0; tick_t = 1'b0;
    chk("rst_go", 0, 64'(ogo[0]), 64'(1'b0));
    chk("rst_y", 0, {20'd0, oy[0][3], oy[0][2], oy[0][1], oy[0][0]},
        {20'd0, 11'd99, 11'd199, 11'd299, 11'd399});
    chk("rst_x", 0, {20'd0, ox[0][3], ox[0][2], ox[0][1], ox[0][0]},
        {20'd0, 11'd80, 11'd420, 11'd160, 11'd300});
    chk("rst_en", 0, 64'(oen[0]), 64'(4'hF));
    chk("rst_score", 0, 64'(osc[0]), 64'(16'd0));
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
